// File: rtl/write_pack_ctrl_if.sv
// write_pack_ctrl_if: configuration, accumulator beat and buffer-write signals of the write-back controller
interface write_pack_ctrl_if #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 13,
    parameter int DATA_LEN     = 32,
    parameter int COM_DATALEN  = 24,
    parameter int MAX_LINE_LEN = 10
);
    localparam int BPW        = DATA_LEN / 8;
    localparam int BUFFER_NUM = X_MAC * X_MESH;
    logic                              conf_valid;
    logic [ADDR_LEN*X_MAC-1:0]         st_addr;
    logic [MAX_LINE_LEN-1:0]           linelen;
    logic [$clog2(X_MAC)-1:0]          bank_sel;
    logic                              pooled;
    logic [1:0]                        relu_mode;
    logic [4:0]                        shift_len;
    logic                              in_valid;
    logic                              in_ready;
    logic [4*COM_DATALEN*X_MESH-1:0]   in_data_4;
    logic [COM_DATALEN*X_MESH-1:0]     in_data_1;
    logic [ADDR_LEN*BUFFER_NUM-1:0]    addra;
    logic [DATA_LEN*BUFFER_NUM-1:0]    data_a;
    logic [BUFFER_NUM-1:0]             wea;
    logic [BPW*BUFFER_NUM-1:0]         bea;
    logic                              done;
    logic                              idle;
    modport slave (
        input  conf_valid, st_addr, linelen, bank_sel, pooled, relu_mode, shift_len,
        input  in_valid, in_data_4, in_data_1,
        output in_ready, addra, data_a, wea, bea, done, idle
    );
    modport master (
        output conf_valid, st_addr, linelen, bank_sel, pooled, relu_mode, shift_len,
        output in_valid, in_data_4, in_data_1,
        input  in_ready, addra, data_a, wea, bea, done, idle
    );
endinterface

// File: rtl/write_pack_ctrl.sv
// write_pack_ctrl: requantises accumulator beats to int8 and packs them into banked buffer writes
module write_pack_ctrl #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 13,
    parameter int DATA_LEN     = 32,
    parameter int COM_DATALEN  = 24,
    parameter int MAX_LINE_LEN = 10
) (
    input logic clk,
    input logic rst,
    write_pack_ctrl_if.slave bus
);
    localparam int BPW = DATA_LEN / 8;
    localparam int BSW = $clog2(X_MAC);
    localparam int PW  = $clog2(BPW);
    localparam int CD  = COM_DATALEN;
    localparam logic signed [CD:0] ONE  = 1;
    localparam logic signed [CD:0] QMAX = 127;
    localparam logic signed [CD:0] QMIN = -128;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_n;

    logic [MAX_LINE_LEN-1:0] beats_left;
    logic [BSW-1:0]          bsel, b1;
    logic                    pooled_r, zero_line;
    logic [1:0]              mode;
    logic [4:0]              shift;
    logic [ADDR_LEN-1:0]     addr [X_MAC];
    logic [7:0]              q [X_MESH][4];
    logic                    v1, last1, accept, wr;
    logic [PW-1:0]           p, lane_hi;
    logic [DATA_LEN-1:0]     acc [X_MESH][2];
    logic [DATA_LEN-1:0]     word [X_MESH][2];
    logic [BPW-1:0]          be;
    logic [X_MAC-1:0]        hit;

    function automatic logic [7:0] requant(input logic signed [CD-1:0] v, input logic [4:0] s, input logic [1:0] m);
        logic signed [CD:0] ext, u, t;
        logic signed [7:0]  r, lk;
        ext = {v[CD-1], v};
        u   = (ext >>> (s - 5'd1)) + ONE;
        t   = (s == 5'd0) ? ext : u >>> 1;
        r   = (t > QMAX) ? 8'h7f : (t < QMIN) ? 8'h80 : t[7:0];
        lk  = r >>> 3;
        return (!r[7] || m == 2'd0) ? r : (m == 2'd2) ? lk : 8'h00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        bus.in_ready = state == RUN;
        bus.idle     = state == IDLE;
        case (state)
            IDLE:    state_n = bus.conf_valid ? ((bus.linelen == '0) ? FLUSH : RUN) : IDLE;
            RUN:     state_n = (accept && beats_left == MAX_LINE_LEN'(1)) ? FLUSH : RUN;
            FLUSH:   state_n = bus.done ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        accept  = bus.in_valid && bus.in_ready;
        lane_hi = pooled_r ? p : p + 1'b1;
        wr      = v1 && (lane_hi == PW'(BPW - 1) || last1);
        b1      = (bsel == BSW'(X_MAC - 1)) ? '0 : bsel + 1'b1;
        be      = BPW'((2 << lane_hi) - 1);
        for (int j = 0; j < X_MAC; j++)
            hit[j] = (BSW'(j) == bsel) || (!pooled_r && BSW'(j) == b1);
        for (int i = 0; i < X_MESH; i++) begin
            word[i][0] = acc[i][0] | (pooled_r ? DATA_LEN'(q[i][0]) : DATA_LEN'({q[i][1], q[i][0]})) << {p, 3'b0};
            word[i][1] = acc[i][1] | DATA_LEN'({q[i][3], q[i][2]}) << {p, 3'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left <= '0;
            bsel       <= '0;
            pooled_r   <= 1'b0;
            zero_line  <= 1'b0;
            mode       <= '0;
            shift      <= '0;
            p          <= '0;
            for (int j = 0; j < X_MAC; j++) addr[j] <= '0;
        end else if (state == IDLE && bus.conf_valid) begin
            beats_left <= bus.linelen;
            bsel       <= bus.bank_sel;
            pooled_r   <= bus.pooled;
            zero_line  <= bus.linelen == '0;
            mode       <= bus.relu_mode;
            shift      <= bus.shift_len;
            p          <= '0;
            for (int j = 0; j < X_MAC; j++) addr[j] <= bus.st_addr[j*ADDR_LEN +: ADDR_LEN];
        end else begin
            if (accept) beats_left <= beats_left - 1'b1;
            if (v1) p <= wr ? '0 : lane_hi + 1'b1;
            for (int j = 0; j < X_MAC; j++)
                if (wr && hit[j]) addr[j] <= addr[j] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v1    <= accept;
            last1 <= accept && beats_left == MAX_LINE_LEN'(1);
        end
        for (int i = 0; i < X_MESH; i++)
            for (int k = 0; k < 4; k++)
                q[i][k] <= requant(pooled_r ? bus.in_data_1[i*CD +: CD] : bus.in_data_4[(i*4+k)*CD +: CD], shift, mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wea    <= '0;
            bus.bea    <= '0;
            bus.data_a <= '0;
            bus.addra  <= '0;
            bus.done   <= 1'b0;
            for (int i = 0; i < X_MESH; i++) begin
                acc[i][0] <= '0;
                acc[i][1] <= '0;
            end
        end else begin
            bus.done <= (wr && last1) || (state == FLUSH && zero_line && !bus.done);
            for (int i = 0; i < X_MESH; i++) begin
                if (v1) acc[i][0] <= wr ? '0 : word[i][0];
                if (v1) acc[i][1] <= wr ? '0 : word[i][1];
                for (int j = 0; j < X_MAC; j++) begin
                    bus.wea[i*X_MAC+j]                      <= wr && hit[j];
                    bus.bea[(i*X_MAC+j)*BPW +: BPW]         <= (wr && hit[j]) ? be : '0;
                    bus.data_a[(i*X_MAC+j)*DATA_LEN +: DATA_LEN] <= !(wr && hit[j]) ? '0 :
                                                               (BSW'(j) == bsel) ? word[i][0] : word[i][1];
                    bus.addra[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] <= addr[j];
                end
            end
        end
    end
endmodule

// File: tb/tb_write_pack_ctrl.sv
// tb_write_pack_ctrl: scoreboard bench driving directed lines through write_pack_ctrl
module tb_write_pack_ctrl;
    localparam int XMAC = 4, XMESH = 2, AL = 13, DL = 32, CD = 24, ML = 10;
    localparam int BN = XMAC * XMESH, BPW = DL / 8;

    typedef struct packed {
        logic [BN-1:0]     wea;
        logic [BPW*BN-1:0] bea;
        logic [DL*BN-1:0]  data;
        logic [AL*BN-1:0]  addr;
        logic              done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    exp_t e;
    exp_t m;

    always #5 clk = ~clk;

    write_pack_ctrl_if #(.X_MAC(XMAC), .X_MESH(XMESH), .ADDR_LEN(AL), .DATA_LEN(DL),
                         .COM_DATALEN(CD), .MAX_LINE_LEN(ML)) bus ();

    write_pack_ctrl #(.X_MAC(XMAC), .X_MESH(XMESH), .ADDR_LEN(AL), .DATA_LEN(DL),
                      .COM_DATALEN(CD), .MAX_LINE_LEN(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if ((|bus.wea) === 1'b1 || bus.done === 1'b1) begin
            if (sb.size() == 0) chk("unexpected write/done", {bus.done, bus.wea}, 64'h0);
            else begin
                m = sb.pop_front();
                chk("wea", bus.wea, m.wea);
                chk("bea", bus.bea, m.bea);
                chk("done", bus.done, m.done);
                checks++;
                if (bus.data_a === m.data) passed++;
                else $display("FAIL data_a: got %h, expected %h", bus.data_a, m.data);
                for (int b = 0; b < BN; b++)
                    if (m.wea[b]) chk("addra", bus.addra[b*AL +: AL], m.addr[b*AL +: AL]);
            end
        end
    end

    task automatic e_new();
        e = '0;
    endtask

    task automatic e_buf(input int b, input logic [DL-1:0] w, input logic [BPW-1:0] be, input int a);
        e.wea[b] = 1'b1;
        e.bea[b*BPW +: BPW] = be;
        e.data[b*DL +: DL] = w;
        e.addr[b*AL +: AL] = AL'(a);
    endtask

    task automatic e_push(input logic d);
        e.done = d;
        sb.push_back(e);
    endtask

    function automatic logic [AL*XMAC-1:0] sa4(input int a0, input int a1, input int a2, input int a3);
        return {AL'(a3), AL'(a2), AL'(a1), AL'(a0)};
    endfunction

    function automatic logic [CD*XMESH-1:0] p1(input int r0, input int r1);
        return {CD'(r1), CD'(r0)};
    endfunction

    function automatic logic [4*CD*XMESH-1:0] p4(input int v[8]);
        logic [4*CD*XMESH-1:0] r;
        for (int k = 0; k < 8; k++) r[k*CD +: CD] = CD'(v[k]);
        return r;
    endfunction

    task automatic cfg(input logic [AL*XMAC-1:0] sa, input int len, input int bs, input bit pl, input int mode, input int sh);
        int n = 0;
        while (bus.idle !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("idle before config", bus.idle, 1);
        bus.conf_valid = 1'b1;
        bus.st_addr    = sa;
        bus.linelen    = ML'(len);
        bus.bank_sel   = 2'(bs);
        bus.pooled     = pl;
        bus.relu_mode  = 2'(mode);
        bus.shift_len  = 5'(sh);
        @(negedge clk);
        bus.conf_valid = 1'b0;
        chk("in_ready after config", bus.in_ready, (len != 0) ? 1 : 0);
    endtask

    task automatic send(input logic [CD*XMESH-1:0] d1, input logic [4*CD*XMESH-1:0] d4);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("in_ready wait", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = d1;
        bus.in_data_4 = d4;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_line();
        int n = 0;
        while ((sb.size() != 0 || bus.idle !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("line drained and idle", {sb.size() == 0, bus.idle}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] neg_exp [4];
        int v[8];
        neg_exp = '{8'hFB, 8'h00, 8'hFF, 8'h00};
        bus.conf_valid = 1'b0;
        bus.st_addr    = '0;
        bus.linelen    = '0;
        bus.bank_sel   = '0;
        bus.pooled     = 1'b0;
        bus.relu_mode  = '0;
        bus.shift_len  = '0;
        bus.in_valid   = 1'b0;
        bus.in_data_1  = '0;
        bus.in_data_4  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", bus.in_ready, 0);
        chk("reset wea", bus.wea, 0);
        chk("reset bea", bus.bea, 0);
        chk("reset done", bus.done, 0);
        chk("reset idle", bus.idle, 1);
        chk("reset addra", |bus.addra, 0);
        chk("reset data_a", |bus.data_a, 0);

        e_new();
        e_buf(1, 32'h04030201, 4'hF, 5);
        e_buf(5, 32'h40302010, 4'hF, 5);
        e_push(1'b1);
        cfg(sa4(100, 5, 200, 300), 4, 1, 1'b1, 0, 0);
        for (int k = 1; k <= 4; k++) send(p1(k, 16 * k), '0);
        chk("no write one cycle after last beat", bus.wea, 0);
        @(negedge clk);
        chk("write two cycles after last beat", bus.wea, 8'h22);
        chk("done with final write", bus.done, 1);
        @(negedge clk);
        chk("idle after done", bus.idle, 1);
        chk("done is one cycle", bus.done, 0);
        wait_line();

        e_new();
        e_buf(1, 32'h04030201, 4'hF, 5);
        e_buf(5, 32'h14131211, 4'hF, 5);
        e_push(1'b0);
        e_new();
        e_buf(1, 32'h00000605, 4'h3, 6);
        e_buf(5, 32'h00001615, 4'h3, 6);
        e_push(1'b1);
        cfg(sa4(100, 5, 200, 300), 6, 1, 1'b1, 0, 0);
        for (int k = 1; k <= 6; k++) send(p1(k, 16 + k), '0);
        wait_line();

        e_new();
        e_buf(3, 32'h0A090201, 4'hF, 20);
        e_buf(0, 32'h0C0B0403, 4'hF, 40);
        e_buf(7, 32'h0E0D0605, 4'hF, 20);
        e_buf(4, 32'h100F0807, 4'hF, 40);
        e_push(1'b0);
        e_new();
        e_buf(3, 32'h1A191211, 4'hF, 21);
        e_buf(0, 32'h1C1B1413, 4'hF, 41);
        e_buf(7, 32'h1E1D1615, 4'hF, 21);
        e_buf(4, 32'h201F1817, 4'hF, 41);
        e_push(1'b1);
        cfg(sa4(40, 0, 0, 20), 4, 3, 1'b0, 0, 0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) v[k] = b * 8 + k + 1;
            send('0, p4(v));
        end
        wait_line();

        e_new();
        e_buf(0, 32'h01807F7D, 4'hF, 9);
        e_buf(4, 32'hFF000201, 4'hF, 9);
        e_push(1'b1);
        cfg(sa4(9, 0, 0, 0), 4, 0, 1'b1, 0, 3);
        send(p1(1000, 8), '0);
        send(p1(1020, 12), '0);
        send(p1(-2000, 0), '0);
        send(p1(4, -8), '0);
        wait_line();

        for (int md = 0; md < 4; md++) begin
            e_new();
            e_buf(2, {24'h0, neg_exp[md]}, 4'h1, 7);
            e_buf(6, 32'h00000005, 4'h1, 7);
            e_push(1'b1);
            cfg(sa4(0, 0, 7, 0), 1, 2, 1'b1, md, 2);
            send(p1(-20, 20), '0);
            wait_line();
        end

        e_new();
        e_buf(0, 32'h04030201, 4'hF, 8191);
        e_buf(4, 32'h00000000, 4'hF, 8191);
        e_push(1'b0);
        e_new();
        e_buf(0, 32'h08070605, 4'hF, 0);
        e_buf(4, 32'h00000000, 4'hF, 0);
        e_push(1'b1);
        cfg(sa4(8191, 0, 0, 0), 8, 0, 1'b1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                bus.conf_valid = 1'b1;
                bus.st_addr    = sa4(1000, 1000, 1000, 1000);
                bus.linelen    = ML'(1);
                bus.bank_sel   = 2'd3;
            end
            if (k == 5) bus.conf_valid = 1'b0;
            send(p1(k, 0), '0);
        end
        chk("busy while config ignored", bus.idle, 0);
        wait_line();

        e_new();
        e_push(1'b1);
        cfg(sa4(1, 1, 1, 1), 0, 0, 1'b1, 0, 0);
        chk("zero line no done yet", bus.done, 0);
        @(negedge clk);
        chk("zero line done", bus.done, 1);
        chk("zero line no write", bus.wea, 0);
        @(negedge clk);
        chk("zero line idle after done", bus.idle, 1);
        wait_line();

        cfg(sa4(50, 50, 50, 50), 8, 0, 1'b1, 0, 0);
        for (int k = 1; k <= 4; k++) send(p1(k, k), '0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset mid-line wea", bus.wea, 0);
        chk("reset mid-line idle", bus.idle, 1);
        chk("reset mid-line in_ready", bus.in_ready, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no write after abort", bus.wea, 0);
        end
        chk("idle after abort", bus.idle, 1);
        chk("scoreboard empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
